// File: rtl/miu_bus_dma.sv
// miu_bus_dma: quadword block-move initiator on the MIU bus_* interface.
// Copies (read-then-write per quadword) or fills (back-to-back writes of a
// fixed pattern) a contiguous, 8-byte aligned region of 64-bit quadwords.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   cfg_src/dst     source/destination byte addresses (sampled on start)
//   cfg_len         quadword count (0 = no-op)
//   cfg_fill        1 = fill with cfg_pattern, 0 = copy
//   cfg_pattern     fill value
//   cfg_start       single-cycle start request, honoured only when idle
//   busy/done/err   status: busy while moving, one-cycle done, sticky err
//   bus_*           MIU initiator request port; bus_rdata is returned the
//                   cycle after a read is accepted
module miu_bus_dma #(
  parameter int LEN_BITS = 16,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   cfg_src,
  input  logic [ADDR_W-1:0]   cfg_dst,
  input  logic [LEN_BITS-1:0] cfg_len,
  input  logic                cfg_fill,
  input  logic [DATA_W-1:0]   cfg_pattern,
  input  logic                cfg_start,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic                bus_valid,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [1:0]          bus_wsize,
  output logic                bus_write,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_ready
);

  // Size encoding: 00 BYTE, 01 WORD, 10 LWRD, 11 QUAD.
  localparam logic [1:0] SIZE_QUAD = 2'b11;

  typedef enum logic [2:0] {IDLE, RD, RWAIT, WR, DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_W-1:0]     src_q, dst_q;
  logic [LEN_BITS-1:0]   rem_q;
  logic [DATA_W-1:0]     data_q, pat_q;
  logic                  fill_q;
  logic                  err_q;
  logic                  accept;
  logic                  start_acc;
  logic                  misaligned;

  assign accept     = bus_valid & bus_ready;
  assign start_acc  = (state == IDLE) & cfg_start;
  // Source alignment only matters when the source is actually read.
  assign misaligned = (cfg_dst[2:0] != 3'b000) |
                      (~cfg_fill & (cfg_src[2:0] != 3'b000));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cfg_start) begin
          if (misaligned || (cfg_len == '0)) state_nxt = DONE;
          else if (cfg_fill)                 state_nxt = WR;
          else                               state_nxt = RD;
        end
      end
      RD:    if (accept) state_nxt = RWAIT;
      RWAIT: state_nxt = WR;
      WR: begin
        if (accept) begin
          if (rem_q == LEN_BITS'(1)) state_nxt = DONE;
          else if (fill_q)           state_nxt = WR;
          else                       state_nxt = RD;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are pure functions of state and registers that only move
  // on acceptance, so they hold steady for the whole of a stall.
  always_comb begin
    bus_valid = 1'b0;
    bus_write = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_wsize = SIZE_QUAD;
    busy      = 1'b0;
    done      = 1'b0;
    err       = err_q;
    case (state)
      RD: begin
        bus_valid = 1'b1;
        bus_addr  = src_q;
        busy      = 1'b1;
      end
      RWAIT: busy = 1'b1;
      WR: begin
        bus_valid = 1'b1;
        bus_write = 1'b1;
        bus_addr  = dst_q;
        bus_wdata = fill_q ? pat_q : data_q;
        busy      = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Control registers: state, sticky error, remaining count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      err_q <= 1'b0;
      rem_q <= '0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        err_q <= misaligned;
        rem_q <= cfg_len;
      end else if ((state == WR) && accept) begin
        rem_q <= rem_q - LEN_BITS'(1);
      end
    end
  end

  // Datapath registers: outputs are masked to zero outside RD/WR, so these
  // need no reset.
  always_ff @(posedge clk) begin
    if (start_acc) begin
      src_q  <= cfg_src;
      dst_q  <= cfg_dst;
      fill_q <= cfg_fill;
      pat_q  <= cfg_pattern;
    end else if ((state == WR) && accept) begin
      src_q <= src_q + ADDR_W'(8);
      dst_q <= dst_q + ADDR_W'(8);
    end
    // Read data arrives the cycle after the read is accepted.
    if (state == RWAIT) data_q <= bus_rdata;
  end

endmodule

// File: tb/tb_miu_bus_dma.sv
// Bench for miu_bus_dma: memory responder with optional random backpressure,
// reference model of the block move as a plain per-quadword loop over an
// associative memory, trace comparison of every accepted bus request.
module tb_miu_bus_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cfg_src, cfg_dst;
  logic [15:0] cfg_len;
  logic        cfg_fill;
  logic [63:0] cfg_pattern;
  logic        cfg_start;
  logic        busy, done, err;
  logic [31:0] bus_addr;
  logic        bus_valid;
  logic [63:0] bus_wdata;
  logic [1:0]  bus_wsize;
  logic        bus_write;
  logic [63:0] bus_rdata;
  logic        bus_ready;

  miu_bus_dma #(.LEN_BITS(16), .ADDR_W(32), .DATA_W(64)) dut (
    .clk(clk), .reset(reset),
    .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
    .cfg_fill(cfg_fill), .cfg_pattern(cfg_pattern), .cfg_start(cfg_start),
    .busy(busy), .done(done), .err(err),
    .bus_addr(bus_addr), .bus_valid(bus_valid), .bus_wdata(bus_wdata),
    .bus_wsize(bus_wsize), .bus_write(bus_write),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [63:0] data;
  } tr_t;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    logic        fill;
    logic [63:0] pat;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int proto_err = 0;
  logic rand_ready = 1'b0;
  logic rd_pending = 1'b0;
  logic [63:0] rd_val;

  logic [63:0] mem [logic [31:0]];
  logic [63:0] ref_mem [logic [31:0]];
  tr_t obs_q[$];
  tr_t exp_q[$];

  logic        prev_stall = 1'b0;
  logic [31:0] p_addr;
  logic [63:0] p_wdata;
  logic        p_write;

  function automatic logic [63:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : {a, ~a};
  endfunction

  function automatic logic [63:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : {a, ~a};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Responder drive: read data and ready change just after the active edge.
  always @(posedge clk) begin
    #1;
    bus_rdata  = rd_pending ? rd_val : 64'h5A5A_A5A5_0F0F_F0F0;
    rd_pending = 1'b0;
    bus_ready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Responder/monitor: sampled mid-cycle, acts on what the next edge accepts.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (bus_valid) begin
        if (bus_wsize != 2'b11 || bus_addr[2:0] != 3'b000) proto_err++;
        if (prev_stall && (bus_addr != p_addr || bus_write != p_write ||
                           (bus_write && bus_wdata != p_wdata))) proto_err++;
      end else if (prev_stall) begin
        proto_err++;
      end
      if (bus_valid && bus_ready) begin
        obs_q.push_back('{bus_write, bus_addr, bus_write ? bus_wdata : 64'h0});
        if (bus_write) mem[bus_addr] = bus_wdata;
        else begin
          rd_val     = mem_rd(bus_addr);
          rd_pending = 1'b1;
        end
      end
      prev_stall = bus_valid && !bus_ready;
      p_addr  = bus_addr;
      p_wdata = bus_wdata;
      p_write = bus_write;
      if (done) done_cnt++;
    end
  end

  task automatic do_start(input logic [31:0] s, input logic [31:0] d,
                          input logic [15:0] l, input logic f, input logic [63:0] p);
    @(posedge clk);
    #2;
    cfg_src = s; cfg_dst = d; cfg_len = l; cfg_fill = f; cfg_pattern = p;
    cfg_start = 1'b1;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
  endtask

  task automatic run_xfer(input logic [31:0] s, input logic [31:0] d,
                          input logic [15:0] l, input logic f, input logic [63:0] p,
                          input logic e_err, input int e_lat, input int extra_at,
                          input string nm);
    logic bad;
    logic [31:0] a_s, a_d;
    logic [63:0] v;
    int k, d0, nbad;
    exp_q.delete();
    bad = (d[2:0] != 3'b000) || (!f && s[2:0] != 3'b000);
    if (!bad) begin
      for (int i = 0; i < int'(l); i++) begin
        a_s = s + 32'(8 * i);
        a_d = d + 32'(8 * i);
        if (f) v = p;
        else begin
          v = ref_rd(a_s);
          exp_q.push_back('{1'b0, a_s, 64'h0});
        end
        exp_q.push_back('{1'b1, a_d, v});
        ref_mem[a_d] = v;
      end
    end
    obs_q.delete();
    proto_err = 0;
    d0 = done_cnt;
    do_start(s, d, l, f, p);
    chk({nm, ".busy_t1"}, 64'(busy), 64'(!bad && l != 16'd0));
    k = 1;
    while (1) begin
      if (k == extra_at) begin
        cfg_src = 32'h4000; cfg_dst = 32'h4800; cfg_len = 16'd1;
        cfg_fill = 1'b0; cfg_pattern = 64'h1111;
        cfg_start = 1'b1;
      end else cfg_start = 1'b0;
      if (done || k >= 3000) break;
      @(posedge clk);
      #1;
      k++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s.timeout actual=no_done required=done", nm);
    end else begin
      if (e_lat > 0) chk({nm, ".latency"}, 64'(k), 64'(e_lat));
      chk({nm, ".busy_at_done"}, 64'(busy), 64'h0);
      chk({nm, ".err"}, 64'(err), 64'(e_err));
    end
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
    chk({nm, ".done_one_cycle"}, 64'(done), 64'h0);
    chk({nm, ".idle_after"}, 64'(busy), 64'h0);
    @(posedge clk);
    #1;
    chk({nm, ".done_pulses"}, 64'(done_cnt - d0), 64'h1);
    chk({nm, ".protocol"}, 64'(proto_err), 64'h0);
    chk({nm, ".trace_len"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk({nm, ".trace_req"}, {31'h0, obs_q[i].wr, obs_q[i].addr},
          {31'h0, exp_q[i].wr, exp_q[i].addr});
      chk({nm, ".trace_data"}, obs_q[i].data, exp_q[i].data);
    end
    nbad = 0;
    foreach (exp_q[i]) if (exp_q[i].wr && mem_rd(exp_q[i].addr) !== ref_rd(exp_q[i].addr)) nbad++;
    chk({nm, ".mem"}, 64'(nbad), 64'h0);
  endtask

  vec_t vecs[10];

  initial begin
    int d0;
    logic [31:0] rs, rd;
    reset = 1'b1; cfg_start = 1'b0;
    cfg_src = '0; cfg_dst = '0; cfg_len = '0; cfg_fill = 1'b0; cfg_pattern = '0;
    bus_ready = 1'b1; bus_rdata = '0;

    vecs[0] = '{32'h0000_0100, 32'h0000_0800, 16'd4, 1'b0, 64'h0, 1'b0, 13};
    vecs[1] = '{32'h0000_0000, 32'h0000_1000, 16'd3, 1'b1, 64'hDEADBEEF_CAFEF00D, 1'b0, 4};
    vecs[2] = '{32'h0000_0100, 32'h0000_0800, 16'd0, 1'b0, 64'h0, 1'b0, 1};
    vecs[3] = '{32'h0000_0100, 32'h0000_0804, 16'd2, 1'b0, 64'h0, 1'b1, 1};
    vecs[4] = '{32'h0000_0200, 32'h0000_0900, 16'd1, 1'b0, 64'h0, 1'b0, 4};
    vecs[5] = '{32'h0000_0103, 32'h0000_0A00, 16'd2, 1'b0, 64'h0, 1'b1, 1};
    vecs[6] = '{32'h0000_0103, 32'h0000_1100, 16'd2, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0, 3};
    vecs[7] = '{32'h0000_0000, 32'hFFFF_FFF8, 16'd2, 1'b1, 64'hA5A5_0000_FFFF_1234, 1'b0, 3};
    vecs[8] = '{32'h0000_0100, 32'h0000_0108, 16'd3, 1'b0, 64'h0, 1'b0, 10};
    vecs[9] = '{32'hFFFF_FFF8, 32'h0000_1200, 16'd2, 1'b0, 64'h0, 1'b0, 7};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", 64'(busy), 64'h0);
    chk("rst.done", 64'(done), 64'h0);
    chk("rst.err", 64'(err), 64'h0);
    chk("rst.valid", 64'(bus_valid), 64'h0);
    chk("rst.write", 64'(bus_write), 64'h0);
    chk("rst.addr", 64'(bus_addr), 64'h0);
    chk("rst.wdata", bus_wdata, 64'h0);
    chk("rst.wsize", 64'(bus_wsize), 64'h3);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Table-driven transfers with ready held high
    foreach (vecs[i])
      run_xfer(vecs[i].src, vecs[i].dst, vecs[i].len, vecs[i].fill, vecs[i].pat,
               vecs[i].exp_err, vecs[i].exp_lat, 0, $sformatf("vec%0d", i));

    // Start ignored while busy, then while in DONE
    run_xfer(32'h0, 32'h3000, 16'd5, 1'b1, 64'h7777_8888_9999_AAAA, 1'b0, 6, 2, "start_busy");
    run_xfer(32'h0, 32'h3100, 16'd2, 1'b1, 64'h1234_5678_9ABC_DEF0, 1'b0, 3, 3, "start_done");

    // Reset during RWAIT of the second quadword
    obs_q.delete();
    d0 = done_cnt;
    ref_mem[32'h0A00] = ref_rd(32'h0300);
    do_start(32'h0300, 32'h0A00, 16'd4, 1'b0, 64'h0);
    repeat (4) @(posedge clk);
    #1;
    chk("rstmid.rwait_valid", 64'(bus_valid), 64'h0);
    chk("rstmid.rwait_busy", 64'(busy), 64'h1);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rstmid.valid", 64'(bus_valid), 64'h0);
    chk("rstmid.busy", 64'(busy), 64'h0);
    repeat (4) @(posedge clk);
    #1;
    chk("rstmid.no_done", 64'(done_cnt - d0), 64'h0);
    chk("rstmid.trace_len", 64'(obs_q.size()), 64'h3);
    chk("rstmid.err", 64'(err), 64'h0);
    run_xfer(32'h0300, 32'h0A00, 16'd4, 1'b0, 64'h0, 1'b0, 13, 0, "rstmid.fresh");

    // Backpressure copy, then randomized transfers
    rand_ready = 1'b1;
    run_xfer(32'h0100, 32'h1800, 16'd8, 1'b0, 64'h0, 1'b0, -1, 0, "bp_copy");
    for (int n = 0; n < 8; n++) begin
      rs = 32'h2000 + 32'(8 * $urandom_range(0, 31));
      rd = 32'h2000 + 32'(8 * $urandom_range(0, 31));
      run_xfer(rs, rd, 16'($urandom_range(1, 8)), 1'($urandom_range(0, 1)),
               {$urandom, $urandom}, 1'b0, -1, 0, $sformatf("rand%0d", n));
    end
    rand_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
